// File: rtl/prbs31_pkg.sv
// rtl/prbs31_pkg.sv - shared PRBS31 constants and checker state encoding
package prbs31_pkg;
    localparam int PRBS31_LEN   = 31;
    localparam int PRBS31_TAP_A = 30;
    localparam int PRBS31_TAP_B = 27;
    localparam logic [PRBS31_LEN-1:0] PRBS31_SEED = 31'd1;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COMPARE = 2'd1,
        LOCKED  = 2'd2
    } prbs_state_e;
endpackage

// File: rtl/prbs31_lfsr.sv
// rtl/prbs31_lfsr.sv - 31-bit PRBS31 shift register with external/feedback load select
module prbs31_lfsr
    import prbs31_pkg::*;
#(
    parameter logic [PRBS31_LEN-1:0] INIT = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  adv,
    input  logic                  use_ext,
    input  logic                  ext,
    output logic [PRBS31_LEN-1:0] sr,
    output logic                  pred
);
    assign pred = sr[PRBS31_TAP_A] ^ sr[PRBS31_TAP_B];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= INIT;
        end else if (adv) begin
            sr <= {sr[PRBS31_LEN-2:0], use_ext ? ext : pred};
        end
    end
endmodule

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - self-synchronising PRBS31 bit-error checker with windowed loss-of-lock
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int LOCK_CNT  = 31,
    parameter int WIN_LOG2  = 10,
    parameter int ERR_LIMIT = 8,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
);
    prbs_state_e cur, nxt;
    logic [4:0] fill_cnt, fill_nxt;
    logic [7:0] match_cnt, match_nxt, match_inc;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0] win_err, win_err_sum;
    logic [PRBS31_LEN-1:0] sr;
    logic pred, err, win_wrap, too_many, unlock;

    // While hunting/comparing the register tracks the line; once locked it free-runs.
    prbs31_lfsr u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv     (en),
        .use_ext (cur != LOCKED),
        .ext     (din),
        .sr      (sr),
        .pred    (pred)
    );

    assign err         = din ^ pred;
    assign win_wrap    = &win_cnt;
    assign win_err_sum = win_wrap ? (WIN_LOG2+1)'(err) : win_err + (WIN_LOG2+1)'(err);
    assign too_many    = win_err_sum >= (WIN_LOG2+1)'(ERR_LIMIT);
    assign match_inc   = match_cnt + 8'd1;

    always_comb begin
        nxt       = cur;
        fill_nxt  = fill_cnt;
        match_nxt = match_cnt;
        unlock    = 1'b0;
        case (cur)
            HUNT: begin
                match_nxt = 8'd0;
                if (fill_cnt != 5'd31) fill_nxt = fill_cnt + 5'd1;
                if (fill_nxt == 5'd31) nxt = COMPARE;
            end
            COMPARE: begin
                if (din == pred && |sr) begin
                    match_nxt = match_inc;
                    if (match_inc == 8'(LOCK_CNT)) nxt = LOCKED;
                end else begin
                    match_nxt = 8'd0;
                end
            end
            LOCKED: begin
                if (too_many) begin
                    nxt       = HUNT;
                    fill_nxt  = 5'd0;
                    match_nxt = 8'd0;
                    unlock    = 1'b1;
                end
            end
            default: nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= HUNT;
            fill_cnt  <= 5'd0;
            match_cnt <= 8'd0;
        end else if (en) begin
            cur       <= nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
        end
    end

    // Window counters restart on unlock so a relock begins with a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else begin
            err_pulse <= en && (cur == LOCKED) && err;
            if (clear) begin
                err_cnt <= '0;
                win_cnt <= '0;
                win_err <= '0;
            end else if (en && cur == LOCKED) begin
                if (err && !(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
                if (unlock) begin
                    win_cnt <= '0;
                    win_err <= '0;
                end else begin
                    win_cnt <= win_cnt + WIN_LOG2'(1);
                    win_err <= win_err_sum;
                end
            end
        end
    end

    assign locked = (cur == LOCKED);
    assign state  = cur;
endmodule
